// File: rtl/opr_fetch_decode.sv
// rtl/opr_fetch_decode.sv - opcode/operand fetch and decode FSM feeding the operand demux
module opr_fetch_decode #(
   parameter logic [7:0] START_ADDR = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] iram_rdata,
   input  logic       exec_done,
   output logic [7:0] iram_addr,
   output logic       iram_rd,
   output logic [7:0] operand,
   output logic [2:0] OPR_sel,
   output logic       opr_valid,
   output logic       busy,
   output logic       halted,
   output logic       illegal
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH_OP  = 3'd1,
      S_LATCH_OP  = 3'd2,
      S_FETCH_OPR = 3'd3,
      S_LATCH_OPR = 3'd4,
      S_ISSUE     = 3'd5,
      S_HALTED    = 3'd6
   } state_t;

   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_JMP  = 8'h05;
   localparam logic [7:0] OP_HALT = 8'hFF;

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_pc;
   logic [7:0] r_opcode;
   logic [7:0] r_operand;
   logic       r_illegal;
   logic       r_start;
   logic       w_has_opr;
   logic       w_illegal_op;

   always_comb begin
      w_has_opr    = (iram_rdata >= 8'h01) && (iram_rdata <= OP_JMP);
      w_illegal_op = (iram_rdata != OP_NOP) && (iram_rdata != OP_HALT) && !w_has_opr;
   end

   // start goes through one register, so the first issue appears five edges after start is sampled
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (r_start) w_next = S_FETCH_OP;
         S_FETCH_OP:  w_next = S_LATCH_OP;
         S_LATCH_OP: begin
            if (iram_rdata == OP_NOP)
               w_next = S_FETCH_OP;
            else if (w_has_opr)
               w_next = S_FETCH_OPR;
            else
               w_next = S_HALTED;
         end
         S_FETCH_OPR: w_next = S_LATCH_OPR;
         S_LATCH_OPR: w_next = (r_opcode == OP_JMP) ? S_FETCH_OP : S_ISSUE;
         S_ISSUE:     if (exec_done) w_next = S_FETCH_OP;
         S_HALTED:    if (r_start) w_next = S_FETCH_OP;
         default:     w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_pc      <= START_ADDR;
         r_opcode  <= 8'h00;
         r_operand <= 8'h00;
         r_illegal <= 1'b0;
         r_start   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_start <= start;
         case (r_state)
            S_LATCH_OP: begin
               r_opcode <= iram_rdata;
               r_pc     <= r_pc + 8'd1;
               if (w_illegal_op)
                  r_illegal <= 1'b1;
            end
            S_LATCH_OPR: begin
               r_operand <= iram_rdata;
               r_pc      <= (r_opcode == OP_JMP) ? iram_rdata : r_pc + 8'd1;
            end
            S_HALTED: begin
               if (r_start) begin
                  r_pc      <= START_ADDR;
                  r_illegal <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign iram_addr = r_pc;
   assign iram_rd   = (r_state == S_FETCH_OP) || (r_state == S_FETCH_OPR);
   assign operand   = r_operand;
   assign opr_valid = (r_state == S_ISSUE);
   assign OPR_sel   = (r_state == S_ISSUE) ? r_opcode[2:0] : 3'b000;
   assign busy      = (r_state != S_IDLE) && (r_state != S_HALTED);
   assign halted    = (r_state == S_HALTED);
   assign illegal   = r_illegal;

endmodule

// File: tb/tb_opr_fetch_decode.sv
// tb/tb_opr_fetch_decode.sv - directed and randomized bench for opr_fetch_decode
module tb_opr_fetch_decode;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] iram_rdata = 8'h00;
   logic       exec_done = 1'b0;
   logic [7:0] iram_addr;
   logic       iram_rd;
   logic [7:0] operand;
   logic [2:0] OPR_sel;
   logic       opr_valid;
   logic       busy;
   logic       halted;
   logic       illegal;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]  mem [0:255];
   logic [10:0] exp_q[$];
   logic [10:0] got_q[$];

   opr_fetch_decode #(.START_ADDR(8'h00)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .iram_rdata(iram_rdata),
      .exec_done(exec_done), .iram_addr(iram_addr), .iram_rd(iram_rd),
      .operand(operand), .OPR_sel(OPR_sel), .opr_valid(opr_valid),
      .busy(busy), .halted(halted), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // synchronous instruction memory: data valid the cycle after the read strobe
   always @(posedge clk) if (iram_rd) iram_rdata <= mem[iram_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic fill_ff();
      for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // instruction-level interpreter of the program held in mem
   task automatic run_model(output logic [7:0] pc_o, output logic ill_o);
      logic [7:0] pc;
      logic [7:0] op;
      logic [7:0] opr;
      pc = 8'h00;
      ill_o = 1'b0;
      exp_q.delete();
      for (int s = 0; s < 64; s++) begin
         op = mem[pc];
         pc = pc + 8'd1;
         if (op == 8'hFF) break;
         if (op > 8'h05) begin
            ill_o = 1'b1;
            break;
         end
         if (op != 8'h00) begin
            opr = mem[pc];
            pc = pc + 8'd1;
            if (op == 8'h05) pc = opr;
            else exp_q.push_back({op[2:0], opr});
         end
      end
      pc_o = pc;
   endtask

   initial begin
      logic       saw;
      logic [7:0] a [0:15];
      logic [2:0] t [0:15];
      logic [7:0] pc;
      logic [7:0] exp_pc;
      logic       exp_ill;
      int         n;

      // reset state
      fill_ff();
      step();
      chk("rst_addr", iram_addr, 8'h00);
      chk("rst_rd", iram_rd, 1'b0);
      chk("rst_operand", operand, 8'h00);
      chk("rst_sel", OPR_sel, 3'b000);
      chk("rst_flags", {opr_valid, busy, halted, illegal}, 4'b0000);

      // RESET instruction, one-cycle issue, then HALT
      fill_ff();
      mem[0] = 8'h01; mem[1] = 8'h5A; mem[2] = 8'hFF;
      exec_done = 1'b1;
      do_reset();
      pulse_start();
      saw = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         step();
         if (opr_valid) saw = 1'b1;
         if (k == 1) chk("s1_fetch_op", {iram_rd, iram_addr}, {1'b1, 8'h00});
         if (k == 2) chk("s1_latch_rd", iram_rd, 1'b0);
         if (k == 3) chk("s1_fetch_opr", {iram_rd, iram_addr}, {1'b1, 8'h01});
      end
      chk("s1_no_early_valid", saw, 1'b0);
      step();
      chk("s1_issue", {opr_valid, OPR_sel, operand}, {1'b1, 3'b001, 8'h5A});
      step();
      chk("s1_next_fetch", {iram_rd, iram_addr, opr_valid, OPR_sel}, {1'b1, 8'h02, 1'b0, 3'b000});
      step();
      step();
      chk("s1_halted", {halted, busy, iram_addr}, {1'b1, 1'b0, 8'h03});

      // INC held for five cycles by exec_done
      fill_ff();
      mem[0] = 8'h04; mem[1] = 8'h11;
      exec_done = 1'b0;
      do_reset();
      pulse_start();
      for (int k = 1; k <= 5; k++) step();
      for (int k = 0; k < 5; k++) begin
         chk("s2_hold", {opr_valid, OPR_sel, operand}, {1'b1, 3'b100, 8'h11});
         if (k == 4) exec_done = 1'b1;
         step();
      end
      chk("s2_release", {opr_valid, OPR_sel, operand}, {1'b0, 3'b000, 8'h11});
      exec_done = 1'b0;

      // JMP 10, then WTR C3
      fill_ff();
      mem[0] = 8'h05; mem[1] = 8'h10;
      mem[8'h10] = 8'h03; mem[8'h11] = 8'hC3; mem[8'h12] = 8'hFF;
      exec_done = 1'b1;
      do_reset();
      pulse_start();
      saw = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         step();
         if (opr_valid) saw = 1'b1;
      end
      chk("s3_jmp_target", {iram_rd, iram_addr}, {1'b1, 8'h10});
      for (int k = 6; k <= 8; k++) begin
         step();
         if (opr_valid) saw = 1'b1;
      end
      chk("s3_jmp_no_issue", saw, 1'b0);
      step();
      chk("s3_wtr", {opr_valid, OPR_sel, operand}, {1'b1, 3'b011, 8'hC3});

      // NOP, NOP, illegal, then restart
      fill_ff();
      mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h07;
      do_reset();
      pulse_start();
      saw = 1'b0;
      for (int k = 0; k < 20 && !halted; k++) begin
         step();
         if (opr_valid) saw = 1'b1;
      end
      chk("s4_halted_illegal", {halted, illegal, busy}, {1'b1, 1'b1, 1'b0});
      chk("s4_pc", iram_addr, 8'h03);
      chk("s4_no_issue", saw, 1'b0);
      pulse_start();
      step();
      chk("s4_restart", {iram_rd, iram_addr, illegal, halted}, {1'b1, 8'h00, 1'b0, 1'b0});

      // WTA across the FE/FF boundary, PC wraps to 00
      fill_ff();
      mem[0] = 8'h05; mem[1] = 8'hFE; mem[8'hFE] = 8'h02; mem[8'hFF] = 8'h33;
      exec_done = 1'b1;
      do_reset();
      pulse_start();
      for (int k = 1; k <= 9; k++) step();
      chk("s5_wta", {opr_valid, OPR_sel, operand}, {1'b1, 3'b010, 8'h33});
      step();
      chk("s5_wrap_fetch", {iram_rd, iram_addr}, {1'b1, 8'h00});

      // reset during ISSUE
      fill_ff();
      mem[0] = 8'h04; mem[1] = 8'h99;
      exec_done = 1'b0;
      do_reset();
      pulse_start();
      for (int k = 1; k <= 5; k++) step();
      chk("s6_in_issue", opr_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("s6_async_rst", {iram_addr, iram_rd, operand, OPR_sel, opr_valid, busy, halted, illegal},
          {8'h00, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0});
      step();
      rst_n = 1'b1;
      saw = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (opr_valid || iram_rd || busy) saw = 1'b1;
      end
      chk("s6_quiet_until_start", saw, 1'b0);

      // randomized programs against the interpreter
      for (int r = 0; r < 8; r++) begin
         fill_ff();
         n = $urandom_range(3, 10);
         pc = 8'h00;
         for (int i = 0; i < n; i++) begin
            t[i] = 3'($urandom_range(0, 5));
            a[i] = pc;
            pc = pc + ((t[i] == 3'd0) ? 8'd1 : 8'd2);
         end
         a[n] = pc;
         mem[pc] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom_range(6, 254));
         for (int i = 0; i < n; i++) begin
            mem[a[i]] = {5'b0, t[i]};
            if (t[i] == 3'd5) mem[a[i] + 8'd1] = a[$urandom_range(i + 1, n)];
            else if (t[i] != 3'd0) mem[a[i] + 8'd1] = 8'($urandom);
         end
         run_model(exp_pc, exp_ill);
         got_q.delete();
         exec_done = 1'b0;
         do_reset();
         pulse_start();
         for (int c = 0; c < 600 && !halted; c++) begin
            exec_done = ($urandom_range(0, 2) != 0);
            if (opr_valid && exec_done) got_q.push_back({OPR_sel, operand});
            step();
         end
         exec_done = 1'b0;
         chk("rand_halted", halted, 1'b1);
         chk("rand_issue_count", got_q.size(), exp_q.size());
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk("rand_issue", got_q[i], exp_q[i]);
         chk("rand_final", {iram_addr, illegal}, {exp_pc, exp_ill});
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/opr_fetch_decode.md
OPR_FETCH_DECODE -- requirements
Module: opr_fetch_decode

Interface
REQ-001: The block SHALL have parameter START_ADDR, default 8'h00, which is the program counter load value on reset and on restart.
REQ-002: The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  input  1  sole clock; all state changes on rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  begin execution; single-cycle pulse or level.
- iram_rdata  input  8  instruction memory read data, valid the cycle after iram_rd.
- exec_done  input  1  downstream stage has consumed the issued operand.
- iram_addr  output  8  instruction memory address (PC).
- iram_rd  output  1  instruction memory read strobe.
- operand  output  8  operand byte to the operand demux.
- OPR_sel  output  3  demux select: 000 none, 001 RESET, 010 WTA, 011 WTR, 100 INC.
- opr_valid  output  1  operand/OPR_sel valid and being issued.
- busy  output  1  high in every state except IDLE and HALTED.
- halted  output  1  high in HALTED.
- illegal  output  1  sticky flag: illegal opcode fetched.

Function
REQ-003: The FSM SHALL have states IDLE, FETCH_OP, LATCH_OP, FETCH_OPR, LATCH_OPR, ISSUE and HALTED.
REQ-004: Opcode map SHALL be:
- 8'h00 NOP
- 8'h01 RESET
- 8'h02 WTA
- 8'h03 WTR
- 8'h04 INC
- 8'h05 JMP
- 8'hFF HALT
- any other value illegal.
REQ-005: IDLE SHALL wait for start=1, then go to FETCH_OP; start SHALL be ignored in every other state except HALTED.
REQ-006: FETCH_OP and FETCH_OPR SHALL drive iram_rd=1 and iram_addr=PC for exactly one cycle; iram_rd SHALL be 0 in all other states.
REQ-007: LATCH_OP SHALL capture iram_rdata as the opcode and increment PC (mod 256, 8'hFF wraps to 8'h00).
REQ-008: From LATCH_OP, the next state SHALL be:
- NOP -> FETCH_OP
- HALT -> HALTED
- illegal -> set illegal=1, go to HALTED
- 01..05 -> FETCH_OPR
REQ-009: LATCH_OPR SHALL capture iram_rdata into operand and increment PC (mod 256).
REQ-010: From LATCH_OPR, JMP SHALL load PC with the operand byte (overriding the increment) and go to FETCH_OP with no issue; opcodes 01..04 SHALL go to ISSUE.
REQ-011: In ISSUE, the block SHALL drive opr_valid=1 and OPR_sel equal to opcode[2:0], holding operand and OPR_sel stable until exec_done=1 is sampled.
REQ-012: exec_done SHALL be sampled only in ISSUE; exec_done=1 on the first ISSUE cycle completes the issue in one cycle; after completion the next state SHALL be FETCH_OP.
REQ-013: OPR_sel SHALL be 3'b000 and opr_valid SHALL be 0 in every state other than ISSUE; operand SHALL retain its last captured value.
REQ-014: Latency SHALL be fixed: with start sampled at edge N, opr_valid first goes high after edge N+5, and the next FETCH_OP is entered at the edge that samples exec_done=1.
REQ-015: HALTED SHALL set halted=1 and busy=0; start=1 in HALTED SHALL load PC=START_ADDR, clear illegal, and go to FETCH_OP.
REQ-016: Illegal opcodes SHALL NOT alter the operand register or PC beyond the opcode increment.

Reset
REQ-017: On rst_n=0 the block SHALL asynchronously and immediately enter IDLE with:
- PC=START_ADDR
- opcode, operand = 8'h00
- OPR_sel=3'b000
- opr_valid, iram_rd, busy, halted, illegal = 0
REQ-018: Reset asserted mid-operation, including during ISSUE, SHALL abandon the instruction with no further strobe or issue; operation SHALL resume only after rst_n=1 and a new start.

Verification
REQ-019: The bench SHALL cover the following directed scenarios:
- IRAM {01,5A,FF}, start -> OPR_sel=001 and operand=5A at edge N+5; exec_done same cycle -> fetch at address 02, halted=1, final PC=03.
- IRAM {04,11}, exec_done held low 4 cycles -> opr_valid, OPR_sel=100 and operand=11 stable for all 5 cycles, then OPR_sel=000.
- IRAM {05,10}, address 10={03,C3,FF} -> no issue for JMP; next iram_addr=10; WTR issued with operand=C3.
- IRAM {00,00,07} -> two NOPs with no issue, then illegal=1 and halted=1 with opr_valid never asserted; start -> PC=START_ADDR and illegal=0.
- PC=FE, IRAM[FE]=02, IRAM[FF]=33 -> WTA issued with operand=33; next fetch at address 00 (wrap).
- rst_n low during ISSUE -> all outputs return to reset values immediately; no issue until a new start.
